// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch (IF) and data load/store (MEM).
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties instead of data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              busy
);

    // Handshake: a requester holds req high until it samples its ack; ack is a
    // one-cycle pulse carrying rdata/err, and req must be low after that edge.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the side not granted last wins; a lone requester always wins.
    assign grant_d = d_req & (~if_req | ~last_grant);
`else
    assign grant_d = d_req;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_sel   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        mem_sel   <= grant_d;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_we    <= grant_d & d_we;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= grant_d;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        err     <= 1'b0;
                        state   <= ST_DONE;
                        if (mem_sel) begin
                            d_rdata <= mem_we ? '0 : mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_DONE;
                        if (mem_sel) begin
                            d_rdata <= '0;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Extra cycle so a req still high while ack is sampled is not re-granted.
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    err    <= 1'b0;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_sel;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_sel(mem_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what the port outputs should hold between transactions.
    logic          exp_sel;
    logic [DW-1:0] exp_if_rd;
    logic [DW-1:0] exp_d_rd;
    bit            last_d;

    typedef struct {
        bit            req_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            w;
        logic [DW-1:0] rdv;
        int            exp_n;
        logic [DW-1:0] exp_rd;
        bit            exp_e;
    } vec_t;

    vec_t vt[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle();
        chk1("idle.busy", busy, 1'b0);
        chk1("idle.mem_req", mem_req, 1'b0);
        chk1("idle.if_ack", if_ack, 1'b0);
        chk1("idle.d_ack", d_ack, 1'b0);
        chk1("idle.err", err, 1'b0);
        chk1("idle.mem_sel", mem_sel, exp_sel);
        chkw("idle.if_rdata", if_rdata, exp_if_rd);
        chkw("idle.d_rdata", d_rdata, exp_d_rd);
    endtask

    task automatic idle_cycle();
        step();
        check_idle();
    endtask

    // Called in an IDLE cycle with the request(s) already driven. Memory answers
    // in BUSY cycle w (w >= n_busy means never within the window).
    task automatic txn(input bit win_d, input int w, input logic [DW-1:0] rdv,
                       input int n_busy, input logic [DW-1:0] exp_rd, input bit exp_e);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wd;
        e_addr  = win_d ? d_addr : if_addr;
        e_we    = win_d ? d_we : 1'b0;
        e_wd    = win_d ? d_wdata : '0;
        exp_sel = win_d;
        for (int i = 0; i < n_busy; i++) begin
            step();
            chk1("busy.mem_req", mem_req, 1'b1);
            chk1("busy.busy", busy, 1'b1);
            chk1("busy.mem_sel", mem_sel, exp_sel);
            chkw("busy.mem_addr", mem_addr, e_addr);
            chk1("busy.mem_we", mem_we, e_we);
            chkw("busy.mem_wdata", mem_wdata, e_wd);
            chk1("busy.if_ack", if_ack, 1'b0);
            chk1("busy.d_ack", d_ack, 1'b0);
            chk1("busy.err", err, 1'b0);
            chkw("busy.if_rdata", if_rdata, exp_if_rd);
            chkw("busy.d_rdata", d_rdata, exp_d_rd);
            mem_ready = (i == w);
            mem_rdata = (i == w) ? rdv : $urandom;
            if (win_d) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 1'($urandom_range(0, 1));
            end else begin
                if_addr = $urandom;
            end
        end
        step();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (win_d) exp_d_rd = exp_rd;
        else exp_if_rd = exp_rd;
        chk1("ack.if_ack", if_ack, !win_d);
        chk1("ack.d_ack", d_ack, win_d);
        chk1("ack.err", err, exp_e);
        chk1("ack.mem_req", mem_req, 1'b0);
        chk1("ack.busy", busy, 1'b1);
        chk1("ack.mem_sel", mem_sel, exp_sel);
        chkw("ack.if_rdata", if_rdata, exp_if_rd);
        chkw("ack.d_rdata", d_rdata, exp_d_rd);
        step();
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
        check_idle();
    endtask

    // Transaction-level expectations from the wait count and request kind.
    task automatic serve_as(input bit win_d, input int w);
        logic [DW-1:0] rdv;
        int            nb;
        bit            e;
        logic [DW-1:0] rd;
        rdv    = $urandom;
        nb     = (w < T) ? w + 1 : T;
        e      = (w >= T);
        rd     = (e || (win_d && d_we)) ? '0 : rdv;
        last_d = win_d;
        txn(win_d, w, rdv, nb, rd, e);
    endtask

    function automatic bit pick_d(input bit pi, input bit pd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (pi && pd) ? !last_d : pd;
`else
        return pd;
`endif
    endfunction

    task automatic serve(input int w);
        serve_as(pick_d(if_req, d_req), w);
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 3, 32'hA5A5_A5A5, 4, 32'h0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0, 2, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0};
        vt[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 99, 32'h1111_1111, 8, 32'h0, 1'b1};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0, 7, 32'h2222_2222, 8, 32'h2222_2222, 1'b0};
        vt[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 99, 32'h3333_3333, 8, 32'h0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0044, 32'h55, 8, 32'h4444_4444, 8, 32'h0, 1'b1};
        vt[7] = '{1'b0, 1'b0, 32'h0000_010C, 32'h0, 1, 32'h0BAD_CAFE, 2, 32'h0BAD_CAFE, 1'b0};

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        exp_sel = 1'b0; exp_if_rd = '0; exp_d_rd = '0; last_d = 1'b1;

        step();
        step();
        check_idle();
        chk1("reset.mem_we", mem_we, 1'b0);
        chkw("reset.mem_addr", mem_addr, '0);
        chkw("reset.mem_wdata", mem_wdata, '0);
        rst = 1'b0;
        idle_cycle();

        // Directed single-requester vectors, each issued in the IDLE cycle after the last.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].req_d) begin
                d_req = 1'b1; d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vt[i].addr;
            end
            last_d = vt[i].req_d;
            txn(vt[i].req_d, vt[i].w, vt[i].rdv, vt[i].exp_n, vt[i].exp_rd, vt[i].exp_e);
        end

        // Back-to-back loads, d_req re-raised in the cycle after each d_ack.
        for (int i = 0; i < 3; i++) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; d_wdata = $urandom;
            serve_as(1'b1, i);
        end
        idle_cycle();

        // Reset while BUSY: transaction dropped, no ack afterwards.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        step();
        chk1("rstmid.mem_req", mem_req, 1'b1);
        step();
        rst = 1'b1; if_req = 1'b0;
        step();
        exp_sel = 1'b0; exp_if_rd = '0; exp_d_rd = '0; last_d = 1'b1;
        rst = 1'b0;
        check_idle();
        for (int i = 0; i < 3; i++) idle_cycle();

        // Simultaneous requests right after reset.
        if_req = 1'b1; if_addr = 32'h0000_0300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; d_wdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        serve_as(1'b0, 1);
        if_req = 1'b1; if_addr = 32'h0000_0304;
        serve_as(1'b1, 0);
        serve_as(1'b0, 2);
`else
        serve_as(1'b1, 1);
        serve_as(1'b0, 0);
`endif
        idle_cycle();

        // Random traffic against the model; waits past T-1 exercise the timeout.
        for (int n = 0; n < 60; n++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if (if_req || d_req) serve(int'($urandom_range(0, 10)));
            else idle_cycle();
        end
        if (if_req || d_req) serve(0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (IF) and the data load/store requester (MEM).
- Owns the select line of the 2:1 address/data mux in front of the port.
- Registers one transaction at a time and holds the mux select for the whole transaction.
- Returns read data and a one-cycle acknowledge to the owning requester; flags a timeout if the memory never responds.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, number of cycles in BUSY without mem_ready before the transaction is aborted with err

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch done pulse
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data done pulse
- d_rdata  out  DATA_W  load data; valid while d_ack=1
- mem_sel  out  1  mux select: 0=IF, 1=MEM
- mem_req  out  1  port request
- mem_we  out  1  port write enable
- mem_addr  out  ADDR_W  port address
- mem_wdata  out  DATA_W  port write data
- mem_rdata  in  DATA_W  port read data; valid with mem_ready
- mem_ready  in  1  port completion; may be high in the first mem_req cycle
- err  out  1  high with an ack pulse when that transaction timed out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset mid-transaction: the transaction is dropped, mem_req drops on the next edge, and no ack is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request pending: remain in IDLE.
  - Any request pending: choose a winner (see arbitration below).
  - On the edge, register mem_sel, mem_addr, mem_we and mem_wdata from the winner, set mem_req=1, and go to BUSY.
  - A fetch winner always drives mem_we=0 and mem_wdata=0.
- Arbitration (base build): d_req has fixed priority over if_req. Data wins so a load/store can drain and the pipeline does not deadlock.
- BUSY:
  - mem_req, mem_sel, mem_addr, mem_we and mem_wdata are held stable.
  - Requester inputs are ignored.
  - The counter increments each cycle.
  - mem_ready=1 at an edge: capture mem_rdata into the owner's rdata register, clear mem_req, err=0, go to DONE.
  - Counter reaching TIMEOUT-1 with mem_ready=0: clear mem_req, set err=1, rdata=0, go to DONE.
  - mem_ready and timeout in the same cycle: mem_ready wins and err=0.
- DONE:
  - The owner's ack is high for exactly one cycle, with rdata and err valid.
  - mem_sel keeps its value.
  - Unconditionally return to IDLE; the counter clears.
  - The requester must drop its req at the edge on which it samples ack.
  - DONE exists so a held req is never re-granted.
- Rdata registers keep their value outside the ack cycle. For stores, d_rdata is 0.
- Latency:
  - req high in cycle 0 gives mem_req in cycle 1.
  - mem_ready in cycle k gives ack in cycle k+1.
  - Minimum transaction is 3 cycles: req at 0, mem_req at 1, ack at 2, IDLE at 3.
  - A next grant issues at the edge ending cycle 3, so its mem_req appears in cycle 4.
- Simultaneous if_req and d_req in IDLE: exactly one is granted. The loser stays pending and is granted at the next IDLE.
- if_ack and d_ack are never high together.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- Defined:
  - A last_grant flop (reset value 1 = data) is updated on every grant.
  - On a tie in IDLE, the requester not granted last wins; the first tie after reset goes to IF.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority and no last_grant flop.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x100, mem_ready=1 in the first mem_req cycle, mem_rdata=0xDEADBEEF -> mem_sel=0 and mem_req in cycle 1, if_ack with if_rdata=0xDEADBEEF in cycle 2, busy=0 in cycle 3.
- Store with wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678, mem_ready after 3 cycles -> mem_sel=1, mem_we=1, address/data held stable 3 cycles, single d_ack, d_rdata=0, err=0.
- Tie: if_req and d_req both asserted in the same cycle:
  - Base build -> data granted first, fetch granted at the next IDLE.
  - With MEM_ARB_ROUND_ROBIN_EN -> fetch first, then data; on a second tie, data first.
- Timeout: TIMEOUT=8, fetch granted, mem_ready held 0 -> mem_req high 8 cycles, then if_ack=1, err=1, if_rdata=0; the next request is served normally.
- Reset mid-operation: rst=1 for 1 cycle during BUSY -> the next cycle mem_req=0, busy=0, no ack ever issued; a new request after reset is served.
- Back-to-back data requests with d_req re-raised the cycle after d_ack:
  - Each gets exactly one ack and one mem_req transaction.
  - d_req held one extra cycle past d_ack is not double-granted.
